// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory read port, consumer valid/ready handshake and
// execute-stage redirect. The master modport is the fetch unit's view.
interface inst_fetch_unit_if #(
    parameter int PC_W   = 8,
    parameter int INST_W = 16
);
    logic              imem_en;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;

    modport master (
        output imem_en, imem_addr, inst_valid, inst, inst_pc,
        input  imem_rdata, inst_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_en, imem_addr, inst_valid, inst, inst_pc,
        output imem_rdata, inst_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC, synchronous imem read, {pc, inst} prefetch FIFO, redirect flush.
// Define IFU_BYPASS_EN to present a response arriving at an empty FIFO in the same cycle.
module inst_fetch_unit #(
    parameter int PC_W   = 8,
    parameter int INST_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    inst_fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] word;
    } entry_t;

    entry_t           fifo_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;

    logic             fifo_empty;
    logic             bypass_hit;
    logic             valid;
    logic             pop;
    logic             pop_fifo;
    logic             push;
    logic             issue;
    logic [CNT_W:0]   occupancy;
    entry_t           out;

    // NOTE: every signal gets a default at the top of the block so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        fifo_empty = (count_q == '0);
`ifdef IFU_BYPASS_EN
        bypass_hit = fifo_empty && inflight_q;
`else
        bypass_hit = 1'b0;
`endif
        valid = !fifo_empty || bypass_hit;
        out   = '0;
        if (!fifo_empty) begin
            out = fifo_q[rd_ptr_q];
        end else if (bypass_hit) begin
            out = {inflight_pc_q, bus.imem_rdata};
        end

        pop      = valid && bus.inst_ready;
        pop_fifo = pop && !fifo_empty;
        // Redirect blocks issue, so the only response that can be outstanding at a
        // redirect lands in that very cycle; suppressing its push here is the kill.
        push     = inflight_q && !bus.redirect && !(bypass_hit && pop);

        // The in-flight word is counted as occupied so its arrival can never overflow.
        occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
        issue     = !RESET && !bus.redirect && (occupancy < (CNT_W + 1)'(DEPTH));

        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;

        if (bus.redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = bus.redirect_pc;
        end else begin
            if (push)     wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_fifo) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop_fifo);
            if (issue)    pc_d = pc_q + PC_W'(1);
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // NOTE: the storage array is not reset; count gates every read, and the output
    // mux drives zero when empty, so stale contents are never visible.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {inflight_pc_q, bus.imem_rdata};
        end
    end

    assign bus.imem_en    = issue;
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = valid;
    assign bus.inst       = out.word;
    assign bus.inst_pc    = out.pc;
endmodule
